// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - opcodes, constants and decode helpers for the MEM stage
package mem_access_ctrl_pkg;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic [31:0] ZERO_WORD     = 32'd0;
    localparam logic        WRITE_DISABLE = 1'b0;

    localparam logic [1:0] MEM_EXCP_NONE    = 2'b00;
    localparam logic [1:0] MEM_EXCP_LOAD_AE = 2'b01;
    localparam logic [1:0] MEM_EXCP_STORE_AE = 2'b10;
    localparam logic [1:0] MEM_EXCP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    function automatic logic is_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return lo[0];
            EXE_LW_OP, EXE_SW_OP:             return |lo;
            default:                          return 1'b0;
        endcase
    endfunction

    // Big-endian: byte offset 0 maps to lane 3 (bits 31:24).
    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] lo);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b1000 >> lo;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return lo[1] ? 4'b0011 : 4'b1100;
            default:                          return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        case (op)
            EXE_SB_OP: return {4{d[7:0]}};
            EXE_SH_OP: return {2{d[15:0]}};
            EXE_SW_OP: return d;
            default:   return ZERO_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/acknowledge data bus between MEM stage and memory
interface mem_access_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    modport master (
        output dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_sel, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// rtl/mem_access_ctrl_load_align.sv - lane selection and sign/zero extension of load data
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = word[{~lane, 3'b000} +: 8];
        h    = lane[1] ? word[15:0] : word[31:16];
        data = word;
        case (op)
            EXE_LB_OP:  data = {{24{b[7]}}, b};
            EXE_LBU_OP: data = {24'd0, b};
            EXE_LH_OP:  data = {{16{h[15]}}, h};
            EXE_LHU_OP: data = {16'd0, h};
            default:    data = word;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM stage: passthrough, load/store bus FSM, alignment and timeout exceptions
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    input  logic        stall_i,
    mem_access_ctrl_if.master dbus,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        stallreq,
    output logic [1:0]  mem_excp
);
    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic        tflag_q;
    logic [31:0] rdata_q;
    logic [7:0]  op_q;
    logic [1:0]  lane_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] load_data;

    logic is_mem, mis, start, cnt_hit;

    assign is_mem  = is_load(ex_aluop) || is_store(ex_aluop);
    assign mis     = misaligned(ex_aluop, ex_mem_addr[1:0]);
    assign start   = (state_q == S_IDLE) && is_mem && !mis;
    assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    mem_access_ctrl_load_align u_align (
        .op   (op_q),
        .lane (lane_q),
        .word (rdata_q),
        .data (load_data)
    );

    // Instruction fields are captured at launch so DONE holds steady however ex_mem behaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            tflag_q         <= 1'b0;
            rdata_q         <= '0;
            op_q            <= '0;
            lane_q          <= '0;
            wd_q            <= '0;
            wreg_q          <= 1'b0;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_sel   <= '0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                dbus.dbus_req   <= 1'b1;
                dbus.dbus_we    <= is_store(ex_aluop);
                dbus.dbus_sel   <= lane_sel(ex_aluop, ex_mem_addr[1:0]);
                dbus.dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
                dbus.dbus_wdata <= store_data(ex_aluop, ex_reg2);
                op_q            <= ex_aluop;
                lane_q          <= ex_mem_addr[1:0];
                wd_q            <= ex_wd;
                wreg_q          <= ex_wreg;
            end
            if (state_q == S_BUSY) begin
                cnt_q <= cnt_q + 1'b1;
                if (dbus.dbus_ack) begin
                    rdata_q       <= dbus.dbus_rdata;
                    dbus.dbus_req <= 1'b0;
                end else if (cnt_hit) begin
                    tflag_q       <= 1'b1;
                    dbus.dbus_req <= 1'b0;
                end
            end
            if (state_q == S_DONE && !stall_i) begin
                cnt_q   <= '0;
                tflag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_wd    = ex_wd;
        mem_wreg  = ex_wreg;
        mem_wdata = ex_wdata;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_whilo = ex_whilo;
        stallreq  = 1'b0;
        mem_excp  = MEM_EXCP_NONE;
        if (!rst) begin
            mem_wd    = NOP_REG_ADDR;
            mem_wreg  = WRITE_DISABLE;
            mem_wdata = ZERO_WORD;
            mem_hi    = ZERO_WORD;
            mem_lo    = ZERO_WORD;
            mem_whilo = WRITE_DISABLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mem) begin
                        mem_wreg  = WRITE_DISABLE;
                        mem_whilo = WRITE_DISABLE;
                        if (mis) begin
                            mem_excp = is_load(ex_aluop) ? MEM_EXCP_LOAD_AE : MEM_EXCP_STORE_AE;
                        end else begin
                            stallreq = 1'b1;
                            state_d  = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    mem_wreg  = WRITE_DISABLE;
                    mem_whilo = WRITE_DISABLE;
                    stallreq  = 1'b1;
                    if (dbus.dbus_ack || cnt_hit) state_d = S_DONE;
                end
                S_DONE: begin
                    mem_wd    = wd_q;
                    mem_wreg  = is_load(op_q) && wreg_q && !tflag_q;
                    mem_wdata = is_load(op_q) ? load_data : ZERO_WORD;
                    mem_whilo = WRITE_DISABLE;
                    if (tflag_q) mem_excp = MEM_EXCP_TIMEOUT;
                    if (!stall_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_reg2 = '0;
    logic        ex_whilo = 1'b0;
    logic [7:0]  ex_aluop = '0;
    logic        stall_i = 1'b0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, stallreq;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [1:0]  mem_excp;
    int errors = 0;
    int checks = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .stall_i(stall_i), .dbus(bus),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .stallreq(stallreq), .mem_excp(mem_excp)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic [31:0] wdata);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wd = wd; ex_wreg = 1'b1; ex_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
        drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd5, 32'h1234);
        #2;
        checks++; if (mem_wd !== 5'd0) begin errors++; $display("FAIL reset_wd got=%h exp=00", mem_wd); end
        checks++; if (mem_wreg !== 1'b0) begin errors++; $display("FAIL reset_wreg got=%b exp=0", mem_wreg); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", mem_wdata); end
        checks++; if (bus.dbus_req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL reset_req got=%b/%b exp=0/0", bus.dbus_req, stallreq); end
        step(); rst = 1'b1;
    endtask

    task automatic test_passthrough();
        drive(EXE_ADD_OP, 32'h0, 32'h0, 5'd5, 32'h1234);
        ex_hi = 32'h1111_2222; ex_whilo = 1'b1;
        #1;
        checks++; if (mem_wd !== 5'd5) begin errors++; $display("FAIL pass_wd got=%h exp=05", mem_wd); end
        checks++; if (mem_wdata !== 32'h1234) begin errors++; $display("FAIL pass_wdata got=%h exp=00001234", mem_wdata); end
        checks++; if (mem_hi !== 32'h1111_2222 || mem_whilo !== 1'b1) begin errors++; $display("FAIL pass_hi got=%h/%b exp=11112222/1", mem_hi, mem_whilo); end
        checks++; if (stallreq !== 1'b0 || mem_wreg !== 1'b1) begin errors++; $display("FAIL pass_stall got=%b/%b exp=0/1", stallreq, mem_wreg); end
        ex_whilo = 1'b0;
        step();
    endtask

    task automatic test_lb();
        drive(EXE_LB_OP, 32'h1001, 32'h0, 5'd3, 32'h0);
        #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_idle got=%b exp=1", stallreq); end
        step();
        checks++; if (bus.dbus_req !== 1'b1 || bus.dbus_we !== 1'b0) begin errors++; $display("FAIL lb_req got=%b/%b exp=1/0", bus.dbus_req, bus.dbus_we); end
        checks++; if (bus.dbus_sel !== 4'b0100) begin errors++; $display("FAIL lb_sel got=%b exp=0100", bus.dbus_sel); end
        checks++; if (bus.dbus_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got=%h exp=00001000", bus.dbus_addr); end
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_busy got=%b exp=1", stallreq); end
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h00F0_0000;
        step();
        bus.dbus_ack = 1'b0;
        checks++; if (mem_wdata !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_data got=%h exp=fffffff0", mem_wdata); end
        checks++; if (mem_wreg !== 1'b1 || mem_wd !== 5'd3) begin errors++; $display("FAIL lb_wreg got=%b/%h exp=1/03", mem_wreg, mem_wd); end
        checks++; if (stallreq !== 1'b0 || bus.dbus_req !== 1'b0) begin errors++; $display("FAIL lb_done got=%b/%b exp=0/0", stallreq, bus.dbus_req); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_sh();
        drive(EXE_SH_OP, 32'h2002, 32'h0000_ABCD, 5'd0, 32'h0);
        step();
        checks++; if (bus.dbus_we !== 1'b1 || bus.dbus_sel !== 4'b0011) begin errors++; $display("FAIL sh_we_sel got=%b/%b exp=1/0011", bus.dbus_we, bus.dbus_sel); end
        checks++; if (bus.dbus_wdata !== 32'hABCD_ABCD || bus.dbus_addr !== 32'h2000) begin errors++; $display("FAIL sh_wdata got=%h/%h exp=abcdabcd/00002000", bus.dbus_wdata, bus.dbus_addr); end
        bus.dbus_ack = 1'b1;
        step();
        bus.dbus_ack = 1'b0;
        checks++; if (mem_wreg !== 1'b0 || mem_excp !== 2'b00) begin errors++; $display("FAIL sh_done got=%b/%b exp=0/00", mem_wreg, mem_excp); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_misaligned();
        drive(EXE_LW_OP, 32'h3001, 32'h0, 5'd4, 32'h0);
        #1;
        checks++; if (mem_excp !== 2'b01 || mem_wreg !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL lw_mis got=%b/%b/%b exp=01/0/0", mem_excp, mem_wreg, stallreq); end
        step();
        checks++; if (bus.dbus_req !== 1'b0) begin errors++; $display("FAIL lw_mis_req got=%b exp=0", bus.dbus_req); end
        drive(EXE_SW_OP, 32'h3002, 32'h0, 5'd0, 32'h0);
        #1;
        checks++; if (mem_excp !== 2'b10 || stallreq !== 1'b0) begin errors++; $display("FAIL sw_mis got=%b/%b exp=10/0", mem_excp, stallreq); end
        drive(EXE_SH_OP, 32'h2001, 32'h0, 5'd0, 32'h0);
        #1;
        checks++; if (mem_excp !== 2'b10) begin errors++; $display("FAIL sh_mis got=%b exp=10", mem_excp); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    task automatic test_timeout();
        drive(EXE_LW_OP, 32'h4000, 32'h0, 5'd6, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.dbus_req !== 1'b1) begin errors++; $display("FAIL to_req_%0d got=%b exp=1", i, bus.dbus_req); end
        end
        step();
        checks++; if (bus.dbus_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got=%b exp=0", bus.dbus_req); end
        checks++; if (mem_excp !== 2'b11 || mem_wreg !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL to_done got=%b/%b/%b exp=11/0/0", mem_excp, mem_wreg, stallreq); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
        checks++; if (mem_excp !== 2'b00) begin errors++; $display("FAIL to_clear got=%b exp=00", mem_excp); end
    endtask

    task automatic test_stall_hold();
        drive(EXE_LHU_OP, 32'h5002, 32'h0, 5'd7, 32'h0);
        step();
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h1234_8765; stall_i = 1'b1;
        step();
        bus.dbus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_wdata !== 32'h0000_8765 || stallreq !== 1'b0 || mem_wreg !== 1'b1) begin errors++; $display("FAIL hold_%0d got=%h/%b/%b exp=00008765/0/1", i, mem_wdata, stallreq, mem_wreg); end
            step();
        end
        stall_i = 1'b0;
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd1, 32'h0000_CAFE);
        step();
        checks++; if (mem_wdata !== 32'h0000_CAFE) begin errors++; $display("FAIL hold_exit got=%h exp=0000cafe", mem_wdata); end
        bus.dbus_ack = 1'b1;
        step();
        bus.dbus_ack = 1'b0;
        checks++; if (bus.dbus_req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL stray_ack got=%b/%b exp=0/0", bus.dbus_req, stallreq); end
    endtask

    task automatic test_reset_mid();
        drive(EXE_LW_OP, 32'h6000, 32'h0, 5'd9, 32'h0);
        step();
        checks++; if (bus.dbus_req !== 1'b1) begin errors++; $display("FAIL rm_busy got=%b exp=1", bus.dbus_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.dbus_req !== 1'b0 || stallreq !== 1'b0 || mem_wreg !== 1'b0) begin errors++; $display("FAIL rm_drop got=%b/%b/%b exp=0/0/0", bus.dbus_req, stallreq, mem_wreg); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step(); rst = 1'b1;
        step();
        checks++; if (bus.dbus_req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL rm_idle got=%b/%b exp=0/0", bus.dbus_req, stallreq); end
    endtask

    task automatic test_back_to_back();
        drive(EXE_LB_OP, 32'h7003, 32'h0, 5'd2, 32'h0);
        step();
        checks++; if (bus.dbus_sel !== 4'b0001) begin errors++; $display("FAIL b2b_sel0 got=%b exp=0001", bus.dbus_sel); end
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h0000_0080;
        step();
        bus.dbus_ack = 1'b0;
        checks++; if (mem_wdata !== 32'hFFFF_FF80 || mem_wd !== 5'd2) begin errors++; $display("FAIL b2b_lb got=%h/%h exp=ffffff80/02", mem_wdata, mem_wd); end
        drive(EXE_LH_OP, 32'h7000, 32'h0, 5'd8, 32'h0);
        step();
        checks++; if (stallreq !== 1'b1 || bus.dbus_req !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b/%b exp=1/0", stallreq, bus.dbus_req); end
        step();
        checks++; if (bus.dbus_sel !== 4'b1100) begin errors++; $display("FAIL b2b_sel1 got=%b exp=1100", bus.dbus_sel); end
        bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h8000_1234;
        step();
        bus.dbus_ack = 1'b0;
        checks++; if (mem_wdata !== 32'hFFFF_8000 || mem_wd !== 5'd8) begin errors++; $display("FAIL b2b_lh got=%h/%h exp=ffff8000/08", mem_wdata, mem_wd); end
        drive(EXE_NOP_OP, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_misaligned();
        test_timeout();
        test_stall_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
